ps2_keycode_decoder: RTL and testbench

Front-end stage that turns raw PS/2 keyboard line activity into the 8-bit key codes the Minesweeper system consumes on its keyCode input. It synchronises ps2_clk and ps2_data, deserialises 11-bit device-to-host frames and checks them. It strips break (F0) and extended (E0) prefixes and emits exactly one single-cycle code per make event. Between events keyCode is 8'h00, so downstream logic treats any non-zero value as a one-shot keypress.

---
 rtl/ps2_keycode_decoder.sv | 136 +++++++++++++
 tb/tb_ps2_keycode_decoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard receiver: synchronises the raw lines, deserialises 11-bit frames and
// emits one single-cycle make code per key press, stripping F0/E0 prefixes.
module ps2_keycode_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyCode,
  output logic       keyValid,
  output logic       extended,
  output logic       frameError
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] clkSync;
  logic [SYNC_STAGES-1:0] dataSync;
  logic                   clkPrev;
  logic                   clkS;
  logic                   dataS;
  logic                   fallEdge;

  logic [1:0]    state;
  logic [7:0]    shiftReg;
  logic [2:0]    bitCnt;
  logic          parityBit;
  logic [CW-1:0] timeoutCnt;
  logic          breakFlag;
  logic          extFlag;
  logic          frameOk;

  assign clkS     = clkSync[SYNC_STAGES-1];
  assign dataS    = dataSync[SYNC_STAGES-1];
  assign fallEdge = clkPrev & ~clkS;
  // Evaluated in the stop-bit edge cycle: stop bit high and odd parity over data+parity.
  assign frameOk  = dataS & (^{shiftReg, parityBit});

  // Synchronisers reset to the idle-high line level so reset release never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clkSync  <= '1;
      dataSync <= '1;
      clkPrev  <= 1'b1;
    end else begin
      clkSync  <= {clkSync[SYNC_STAGES-2:0], ps2_clk};
      dataSync <= {dataSync[SYNC_STAGES-2:0], ps2_data};
      clkPrev  <= clkS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shiftReg   <= 8'h00;
      bitCnt     <= 3'd0;
      parityBit  <= 1'b0;
      timeoutCnt <= '0;
      breakFlag  <= 1'b0;
      extFlag    <= 1'b0;
      keyCode    <= 8'h00;
      keyValid   <= 1'b0;
      extended   <= 1'b0;
      frameError <= 1'b0;
    end else begin
      keyCode    <= 8'h00;
      keyValid   <= 1'b0;
      extended   <= 1'b0;
      frameError <= 1'b0;
      if (state == IDLE) begin
        timeoutCnt <= '0;
        bitCnt     <= 3'd0;
        if (fallEdge && !dataS) begin
          state <= DATA;
        end
      end else if (fallEdge) begin
        timeoutCnt <= '0;
        case (state)
          DATA: begin
            shiftReg <= {dataS, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parityBit <= dataS;
            state     <= STOP;
          end
          STOP: begin
            state  <= IDLE;
            bitCnt <= 3'd0;
            // A zero byte is the keyboard's overrun report, so it counts as an error.
            if (!frameOk || shiftReg == 8'h00) begin
              frameError <= 1'b1;
              breakFlag  <= 1'b0;
              extFlag    <= 1'b0;
            end else if (shiftReg == 8'hF0) begin
              breakFlag <= 1'b1;
            end else if (shiftReg == 8'hE0) begin
              extFlag <= 1'b1;
            end else begin
              if (!breakFlag) begin
                keyCode  <= shiftReg;
                keyValid <= 1'b1;
                extended <= extFlag;
              end
              breakFlag <= 1'b0;
              extFlag   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (timeoutCnt == TIMEOUT_LAST) begin
        state      <= IDLE;
        frameError <= 1'b1;
        breakFlag  <= 1'b0;
        extFlag    <= 1'b0;
        shiftReg   <= 8'h00;
        bitCnt     <= 3'd0;
        timeoutCnt <= '0;
      end else begin
        timeoutCnt <= timeoutCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Directed bench for ps2_keycode_decoder: drives PS/2 frames and scoreboards every
// output pulse (code, extended flag, error flag and latency from the last clock fall).
module tb_ps2_keycode_decoder;

  localparam int SYNC    = 2;
  localparam int TIMEOUT = 600;
  localparam int HP      = 20;           // PS/2 half-bit in clk cycles
  localparam int LAT     = SYNC + 1;     // clk posedges from driven clock fall to output

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keyCode;
  logic       keyValid;
  logic       extended;
  logic       frameError;

  // Entry: {latency[15:0], frameError, extended, keyCode[7:0]}
  logic [25:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [31:0] cycleCnt = 0;
  logic [31:0] lastFall = 0;

  ps2_keycode_decoder #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyCode(keyCode), .keyValid(keyValid), .extended(extended), .frameError(frameError)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input logic err, input logic ext, input logic [7:0] code,
                                   input int dly);
    logic [15:0] d;
    d = dly[15:0];
    exp_q.push_back({d, err, ext, code});
  endfunction

  // driver tasks
  task automatic ps2_bit(input logic v);
    repeat (HP) @(posedge clk);
    #1 ps2_data = v;
    repeat (HP) @(posedge clk);
    #1 ps2_clk = 1'b0;
    lastFall = cycleCnt;
    repeat (HP) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit badParity, input bit badStop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ badParity);
    ps2_bit(~badStop);
    #1 ps2_data = 1'b1;
  endtask

  task automatic drain(input string tag);
    repeat (20) @(posedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  // scoreboard: every output pulse must match the head of the expected queue
  always @(negedge clk) begin
    logic [25:0] e;
    if (!reset && (keyValid || frameError || keyCode != 8'h00 || extended)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {frameError, extended, keyValid, keyCode}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("out_value", {frameError, extended, keyCode}, e[9:0]);
        check("out_valid", keyValid, !e[9]);
        check("out_latency", cycleCnt - lastFall, e[25:10]);
      end
    end
  end

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_keyCode", keyCode, 8'h00);
    check("rst_keyValid", keyValid, 0);
    check("rst_extended", extended, 0);
    check("rst_frameError", frameError, 0);
    reset = 1'b0;

    // idle lines: no pulse may appear
    repeat (2000) @(posedge clk);
    drain("idle");

    push_exp(0, 0, 8'h1D, LAT);
    send_frame(8'h1D, 0, 0);
    drain("make_1d");

    send_frame(8'hF0, 0, 0);
    send_frame(8'h1D, 0, 0);
    drain("break_1d");
    push_exp(0, 0, 8'h1D, LAT);
    send_frame(8'h1D, 0, 0);
    drain("make_after_break");

    send_frame(8'hE0, 0, 0);
    push_exp(0, 1, 8'h75, LAT);
    send_frame(8'h75, 0, 0);
    drain("ext_make_75");

    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    drain("ext_break_75");
    push_exp(0, 0, 8'h1D, LAT);
    send_frame(8'h1D, 0, 0);
    drain("ext_cleared");

    push_exp(1, 0, 8'h00, LAT);
    send_frame(8'h1D, 1, 0);
    drain("bad_parity");
    push_exp(0, 0, 8'h23, LAT);
    send_frame(8'h23, 0, 0);
    drain("make_23");

    // five edges then silence: timeout error expected
    push_exp(1, 0, 8'h00, LAT + TIMEOUT);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    #1 ps2_data = 1'b1;
    repeat (TIMEOUT + 50) @(posedge clk);
    check("timeout_seen", exp_q.size(), 0);
    push_exp(0, 0, 8'h1C, LAT);
    send_frame(8'h1C, 0, 0);
    drain("after_timeout");

    push_exp(1, 0, 8'h00, LAT);
    send_frame(8'h1C, 0, 1);
    drain("bad_stop");
    push_exp(1, 0, 8'h00, LAT);
    send_frame(8'h00, 0, 0);
    drain("overrun_00");

    // typematic repeats are not suppressed
    push_exp(0, 0, 8'h1C, LAT);
    send_frame(8'h1C, 0, 0);
    push_exp(0, 0, 8'h1C, LAT);
    send_frame(8'h1C, 0, 0);
    drain("typematic");

    // partial frame after F0, then reset: flags and shift state must be gone
    send_frame(8'hF0, 0, 0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_keyValid", keyValid, 0);
    check("midrst_frameError", frameError, 0);
    reset = 1'b0;
    push_exp(0, 0, 8'h1C, LAT);
    send_frame(8'h1C, 0, 0);
    drain("after_midreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard bound on simulated time
  initial begin
    #5_000_000;
    bad++;
    $display("FAIL watchdog expired got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
